// File: rtl/anton_neopixel_rx_pkg.sv
// ---------------------------------------------------------------------------
// anton_neopixel_rx_pkg : shared defaults, state encoding and helpers for the
// NeoPixel receiver.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package anton_neopixel_rx_pkg;

  // Last pixel-buffer byte address; same default as the transmitter (256 RGB LEDs).
  localparam int C_BUFFER_END_DEFAULT       = 767;
  localparam int C_RX_GAP_TICKS_DEFAULT     = 320;
  localparam int C_RX_ONE_THRESHOLD_DEFAULT = 4;
  localparam int C_RX_MIN_HIGH_DEFAULT      = 2;
  localparam int C_RX_MAX_HIGH_DEFAULT      = 7;

  localparam logic [1:0] C_ST_SYNC = 2'd0;
  localparam logic [1:0] C_ST_IDLE = 2'd1;
  localparam logic [1:0] C_ST_HIGH = 2'd2;
  localparam logic [1:0] C_ST_LOW  = 2'd3;

  typedef enum logic [1:0] {
    ST_SYNC = C_ST_SYNC,
    ST_IDLE = C_ST_IDLE,
    ST_HIGH = C_ST_HIGH,
    ST_LOW  = C_ST_LOW
  } state_t;

  // Bit positions inside errFlags.
  localparam int C_ERR_GLITCH    = 0;
  localparam int C_ERR_LONG_HIGH = 1;
  localparam int C_ERR_OVERFLOW  = 2;
  localparam int C_ERR_PARTIAL   = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/anton_neopixel_rx_if.sv
// ---------------------------------------------------------------------------
// anton_neopixel_rx_if : line input, control and write-stream outputs of the
// receiver.  NEO_RX_STATS_EN adds the statistics counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface anton_neopixel_rx_if;
  logic        neoDataIn;
  logic        errClear;
  logic [13:0] rxAddr;
  logic [7:0]  rxData;
  logic        rxWrite;
  logic        frameDone;
  logic [13:0] frameBytes;
  logic        busy;
  logic [3:0]  errFlags;
`ifdef NEO_RX_STATS_EN
  logic [15:0] frameCount;
  logic [15:0] errCount;

  modport master (
    output neoDataIn, errClear,
    input  rxAddr, rxData, rxWrite, frameDone, frameBytes, busy, errFlags,
    input  frameCount, errCount
  );
  modport slave (
    input  neoDataIn, errClear,
    output rxAddr, rxData, rxWrite, frameDone, frameBytes, busy, errFlags,
    output frameCount, errCount
  );
`else
  modport master (
    output neoDataIn, errClear,
    input  rxAddr, rxData, rxWrite, frameDone, frameBytes, busy, errFlags
  );
  modport slave (
    input  neoDataIn, errClear,
    output rxAddr, rxData, rxWrite, frameDone, frameBytes, busy, errFlags
  );
`endif
endinterface

`default_nettype wire

// File: rtl/anton_neopixel_rx_sync.sv
// ---------------------------------------------------------------------------
// anton_neopixel_rx_sync : two-flop synchroniser plus previous-level register
// giving the settled line level and single-cycle rise/fall flags.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module anton_neopixel_rx_sync (
  input  logic clk6_4mhz,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk6_4mhz) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/anton_neopixel_rx.sv
// ---------------------------------------------------------------------------
// anton_neopixel_rx : decodes the NeoPixel line by high-pulse width into an
// MSB-first byte write stream; NEO_RX_STATS_EN adds frame/error counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module anton_neopixel_rx
  import anton_neopixel_rx_pkg::*;
#(
  parameter int BUFFER_END    = C_BUFFER_END_DEFAULT,
  parameter int RX_GAP_TICKS  = C_RX_GAP_TICKS_DEFAULT,
  parameter int ONE_THRESHOLD = C_RX_ONE_THRESHOLD_DEFAULT,
  parameter int MIN_HIGH      = C_RX_MIN_HIGH_DEFAULT,
  parameter int MAX_HIGH      = C_RX_MAX_HIGH_DEFAULT
) (
  input  logic               clk6_4mhz,
  input  logic               reset,
  anton_neopixel_rx_if.slave bus
);

  localparam logic [13:0] C_END      = 14'(BUFFER_END);
  localparam logic [13:0] C_ADDR_MAX = 14'h3FFF;
  localparam logic [15:0] C_GAP      = 16'(RX_GAP_TICKS);
  localparam logic [15:0] C_ONE      = 16'(ONE_THRESHOLD);
  localparam logic [15:0] C_MIN      = 16'(MIN_HIGH);
  localparam logic [15:0] C_LONG     = 16'(MAX_HIGH + 1);

  logic w_level, w_rise, w_fall;

  anton_neopixel_rx_sync u_sync (
    .clk6_4mhz (clk6_4mhz),
    .reset     (reset),
    .din       (bus.neoDataIn),
    .level     (w_level),
    .rise      (w_rise),
    .fall      (w_fall)
  );

  state_t      r_state,       w_state;
  logic [15:0] r_high_cnt,    w_high_cnt;
  logic [15:0] r_low_cnt,     w_low_cnt;
  logic [2:0]  r_bit_idx,     w_bit_idx;
  logic [7:0]  r_shift,       w_shift;
  logic [13:0] r_rx_addr,     w_rx_addr;
  logic [7:0]  r_rx_data,     w_rx_data;
  logic        r_rx_write,    w_rx_write;
  logic        r_frame_done,  w_frame_done;
  logic [13:0] r_frame_bytes, w_frame_bytes;
  logic [13:0] r_byte_cnt,    w_byte_cnt;
  logic        r_byte_done,   w_byte_done;
  logic [3:0]  r_err_flags,   w_err_flags;
  logic [3:0]  w_err_new;
  logic        w_new_bit;
  logic [7:0]  w_byte;

  always_comb begin
    w_state       = r_state;
    w_high_cnt    = r_high_cnt;
    w_low_cnt     = r_low_cnt;
    w_bit_idx     = r_bit_idx;
    w_shift       = r_shift;
    w_rx_addr     = r_rx_addr;
    w_rx_data     = r_rx_data;
    w_rx_write    = 1'b0;
    w_frame_done  = 1'b0;
    w_frame_bytes = r_frame_bytes;
    w_byte_cnt    = r_byte_cnt;
    w_byte_done   = 1'b0;
    w_err_new     = 4'b0000;
    w_new_bit     = (r_high_cnt >= C_ONE);
    w_byte        = {r_shift[6:0], w_new_bit};

    // The address advances only after the strobe cycle, so rxAddr stays valid with rxWrite.
    if (r_byte_done) begin
      if ((r_rx_addr <= C_END) && (r_rx_addr != C_ADDR_MAX)) w_rx_addr = r_rx_addr + 14'd1;
      if (r_byte_cnt != C_ADDR_MAX) w_byte_cnt = r_byte_cnt + 14'd1;
    end

    case (r_state)
      ST_SYNC: begin
        if (w_level) begin
          w_low_cnt = 16'd0;
        end else begin
          w_low_cnt = sat_inc16(r_low_cnt);
          if (w_low_cnt == C_GAP) w_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_rise) begin
          w_state    = ST_HIGH;
          w_high_cnt = 16'd1;
          w_bit_idx  = 3'd0;
          w_rx_addr  = 14'd0;
          w_byte_cnt = 14'd0;
        end
      end
      ST_HIGH: begin
        if (w_fall) begin
          w_low_cnt = 16'd1;
          if (r_high_cnt < C_MIN) begin
            w_err_new[C_ERR_GLITCH] = 1'b1;
            w_state                 = ST_SYNC;
          end else begin
            w_state   = ST_LOW;
            w_shift   = w_byte;
            w_bit_idx = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              w_rx_data   = w_byte;
              w_byte_done = 1'b1;
              if (r_rx_addr <= C_END) w_rx_write = 1'b1;
              else                    w_err_new[C_ERR_OVERFLOW] = 1'b1;
            end
          end
        end else begin
          w_high_cnt = sat_inc16(r_high_cnt);
          if (w_high_cnt == C_LONG) begin
            w_err_new[C_ERR_LONG_HIGH] = 1'b1;
            w_state                    = ST_SYNC;
            w_low_cnt                  = 16'd0;
          end
        end
      end
      ST_LOW: begin
        if (w_rise) begin
          w_state    = ST_HIGH;
          w_high_cnt = 16'd1;
        end else begin
          w_low_cnt = sat_inc16(r_low_cnt);
          if (w_low_cnt == C_GAP) begin
            w_frame_done  = 1'b1;
            w_frame_bytes = w_byte_cnt;
            w_state       = ST_IDLE;
            if (r_bit_idx != 3'd0) begin
              w_err_new[C_ERR_PARTIAL] = 1'b1;
              w_bit_idx                = 3'd0;
            end
          end
        end
      end
      default: w_state = ST_SYNC;
    endcase

    w_err_flags = (bus.errClear ? 4'b0000 : r_err_flags) | w_err_new;
  end

  always_ff @(posedge clk6_4mhz) begin
    if (reset) begin
      r_state       <= ST_SYNC;
      r_high_cnt    <= 16'd0;
      r_low_cnt     <= 16'd0;
      r_bit_idx     <= 3'd0;
      r_shift       <= 8'd0;
      r_rx_addr     <= 14'd0;
      r_rx_data     <= 8'd0;
      r_rx_write    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_bytes <= 14'd0;
      r_byte_cnt    <= 14'd0;
      r_byte_done   <= 1'b0;
      r_err_flags   <= 4'b0000;
    end else begin
      r_state       <= w_state;
      r_high_cnt    <= w_high_cnt;
      r_low_cnt     <= w_low_cnt;
      r_bit_idx     <= w_bit_idx;
      r_shift       <= w_shift;
      r_rx_addr     <= w_rx_addr;
      r_rx_data     <= w_rx_data;
      r_rx_write    <= w_rx_write;
      r_frame_done  <= w_frame_done;
      r_frame_bytes <= w_frame_bytes;
      r_byte_cnt    <= w_byte_cnt;
      r_byte_done   <= w_byte_done;
      r_err_flags   <= w_err_flags;
    end
  end

  assign bus.rxAddr     = r_rx_addr;
  assign bus.rxData     = r_rx_data;
  assign bus.rxWrite    = r_rx_write;
  assign bus.frameDone  = r_frame_done;
  assign bus.frameBytes = r_frame_bytes;
  assign bus.busy       = (r_state == ST_HIGH) || (r_state == ST_LOW);
  assign bus.errFlags   = r_err_flags;

`ifdef NEO_RX_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk6_4mhz) begin
    if (reset) begin
      r_frame_count <= 16'd0;
      r_err_count   <= 16'd0;
    end else begin
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
      if (|w_err_new)   r_err_count   <= r_err_count + 16'd1;
    end
  end

  assign bus.frameCount = r_frame_count;
  assign bus.errCount   = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_anton_neopixel_rx.sv
// ---------------------------------------------------------------------------
// tb_anton_neopixel_rx : directed self-checking bench for the NeoPixel receiver
// (BUFFER_END = 2 so one instance also covers buffer overflow).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_anton_neopixel_rx;

  localparam int GAP = 320;

  logic clk;
  logic reset;

  anton_neopixel_rx_if bus();

  anton_neopixel_rx #(
    .BUFFER_END (2)
  ) dut (
    .clk6_4mhz (clk),
    .reset     (reset),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #78 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write-stream log, filled independently of the stimulus.
  int          n_wr   = 0;
  int          n_done = 0;
  logic [13:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];

  always @(negedge clk) begin
    if (bus.rxWrite === 1'b1 && n_wr < 64) begin
      wr_addr[n_wr] = bus.rxAddr;
      wr_data[n_wr] = bus.rxData;
      n_wr = n_wr + 1;
    end
    if (bus.frameDone === 1'b1) n_done = n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.neoDataIn = 1'b1;
    ticks(b ? 5 : 2);
    bus.neoDataIn = 1'b0;
    ticks(b ? 3 : 6);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Whole byte except the low phase of its last bit, which the gap supplies.
  task automatic send_byte_open(input logic [7:0] v);
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    bus.neoDataIn = 1'b1;
    ticks(v[0] ? 5 : 2);
  endtask

  task automatic gap_watch(input int n, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    bus.neoDataIn = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (bus.frameDone === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic clear_errors();
    bus.errClear = 1'b1;
    ticks(1);
    bus.errClear = 1'b0;
    ticks(1);
  endtask

  int first, cnt, base, base_done;

  initial begin
    bus.neoDataIn = 1'b0;
    bus.errClear  = 1'b0;
    reset         = 1'b1;
    ticks(4);

    // Reset state
    chk("rst_addr",       32'(bus.rxAddr),     32'd0);
    chk("rst_data",       32'(bus.rxData),     32'd0);
    chk("rst_write",      32'(bus.rxWrite),    32'd0);
    chk("rst_done",       32'(bus.frameDone),  32'd0);
    chk("rst_framebytes", 32'(bus.frameBytes), 32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_errflags",   32'(bus.errFlags),   32'd0);
    reset = 1'b0;

    // Two clean bytes; frameDone must land on low tick GAP (bench tick GAP+2) only once.
    ticks(330);
    base = n_wr;
    send_byte(8'hA5);
    chk("t1_busy_mid", 32'(bus.busy), 32'd1);
    send_byte_open(8'h3C);
    gap_watch(400, first, cnt);
    chk("t1_done_tick",   32'(first), 32'(GAP + 2));
    chk("t1_done_count",  32'(cnt), 32'd1);
    chk("t1_nwrites",     32'(n_wr - base), 32'd2);
    chk("t1_addr0",       32'(wr_addr[base]),     32'd0);
    chk("t1_data0",       32'(wr_data[base]),     32'hA5);
    chk("t1_addr1",       32'(wr_addr[base + 1]), 32'd1);
    chk("t1_data1",       32'(wr_data[base + 1]), 32'h3C);
    chk("t1_framebytes",  32'(bus.frameBytes), 32'd2);
    chk("t1_errflags",    32'(bus.errFlags), 32'd0);
    chk("t1_busy_idle",   32'(bus.busy), 32'd0);

    // One-tick pulse is a glitch; decoding resumes after resync.
    bus.neoDataIn = 1'b1;
    ticks(1);
    bus.neoDataIn = 1'b0;
    ticks(8);
    chk("t2_glitch", 32'(bus.errFlags), 32'h1);
    chk("t2_busy",   32'(bus.busy), 32'd0);
    ticks(330);
    base = n_wr;
    send_byte_open(8'h5A);
    gap_watch(330, first, cnt);
    chk("t2_done_count", 32'(cnt), 32'd1);
    chk("t2_nwrites",    32'(n_wr - base), 32'd1);
    chk("t2_data",       32'(wr_data[base]), 32'h5A);
    chk("t2_sticky",     32'(bus.errFlags), 32'h1);
    clear_errors();
    chk("t2_cleared",    32'(bus.errFlags), 32'h0);

    // Line held high 8 ticks is stuck-high; a following frame still decodes.
    bus.neoDataIn = 1'b1;
    ticks(8);
    bus.neoDataIn = 1'b0;
    ticks(6);
    chk("t3_longhigh", 32'(bus.errFlags), 32'h2);
    chk("t3_busy",     32'(bus.busy), 32'd0);
    ticks(330);
    base = n_wr;
    send_byte_open(8'hFF);
    gap_watch(330, first, cnt);
    chk("t3_done_count", 32'(cnt), 32'd1);
    chk("t3_nwrites",    32'(n_wr - base), 32'd1);
    chk("t3_addr",       32'(wr_addr[base]), 32'd0);
    chk("t3_data",       32'(wr_data[base]), 32'hFF);
    clear_errors();

    // Four bytes into a three-byte buffer.
    base = n_wr;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte_open(8'h44);
    gap_watch(330, first, cnt);
    chk("t4_nwrites",    32'(n_wr - base), 32'd3);
    chk("t4_addr2",      32'(wr_addr[base + 2]), 32'd2);
    chk("t4_data2",      32'(wr_data[base + 2]), 32'h33);
    chk("t4_data0",      32'(wr_data[base]), 32'h11);
    chk("t4_overflow",   32'(bus.errFlags), 32'h4);
    chk("t4_framebytes", 32'(bus.frameBytes), 32'd4);
    chk("t4_addr_sat",   32'(bus.rxAddr), 32'd3);
    chk("t4_done_count", 32'(cnt), 32'd1);
    clear_errors();

    // One byte plus three bits, then the gap.
    base = n_wr;
    send_byte(8'h81);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.neoDataIn = 1'b1;
    ticks(5);
    gap_watch(330, first, cnt);
    chk("t5_nwrites",    32'(n_wr - base), 32'd1);
    chk("t5_data",       32'(wr_data[base]), 32'h81);
    chk("t5_partial",    32'(bus.errFlags), 32'h8);
    chk("t5_done_count", 32'(cnt), 32'd1);
    chk("t5_framebytes", 32'(bus.frameBytes), 32'd1);
    clear_errors();

    // Reset in the middle of the second byte of a frame.
    send_byte(8'h77);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("t5_addr_before_rst", 32'(bus.rxAddr), 32'd1);
    base      = n_wr;
    base_done = n_done;
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(400);
    chk("t5_rst_nwrites", 32'(n_wr - base), 32'd0);
    chk("t5_rst_ndone",   32'(n_done - base_done), 32'd0);
    chk("t5_rst_addr",    32'(bus.rxAddr), 32'd0);
    chk("t5_rst_err",     32'(bus.errFlags), 32'd0);

    // Three clean frames and one glitch since the last reset.
    base = n_wr;
    send_byte_open(8'h00);
    gap_watch(330, first, cnt);
    chk("t6_f1_done_tick", 32'(first), 32'(GAP + 2));
    send_byte_open(8'hC3);
    gap_watch(330, first, cnt);
    chk("t6_f2_done_count", 32'(cnt), 32'd1);
    send_byte_open(8'h7E);
    gap_watch(330, first, cnt);
    chk("t6_f3_done_count", 32'(cnt), 32'd1);
    bus.neoDataIn = 1'b1;
    ticks(1);
    bus.neoDataIn = 1'b0;
    ticks(8);
    chk("t6_nwrites", 32'(n_wr - base), 32'd3);
    chk("t6_data0",   32'(wr_data[base]),     32'h00);
    chk("t6_data1",   32'(wr_data[base + 1]), 32'hC3);
    chk("t6_data2",   32'(wr_data[base + 2]), 32'h7E);
    chk("t6_glitch",  32'(bus.errFlags), 32'h1);
`ifdef NEO_RX_STATS_EN
    chk("t6_frame_count", 32'(bus.frameCount), 32'd3);
    chk("t6_err_count",   32'(bus.errCount),   32'd1);
    clear_errors();
    chk("t6_count_keep",  32'(bus.frameCount), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
